// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types, constants and the hex glyph table for the
//                seg_scan_mux seven-segment scanner.
//                Segment vectors are active-high internally, with bit 6 = a
//                down to bit 0 = g.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Width of the digit index (enough for 8 digits)
    localparam int IDX_W = $clog2(8);

    // All segments dark, active-high encoding
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // A captured display word: eight nibbles plus per-digit enables
    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  en;
    } seg_word_t;

    // Standard hex glyphs: b and d lowercase, A C E F uppercase.
    // Bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_mux_if
//  Description : Load bus between the datapath (master) and the display
//                scanner (slave).
//                VALUE   - 32-bit hex word, nibble i shown on digit i
//                DIG_EN  - per-digit enable, 0 blanks the digit
//                LOAD    - single-cycle capture strobe
//                PENDING - a captured word is waiting for the frame boundary
//                DP_IN   - per-digit decimal points (only with SEG_SCAN_DP_EN)
//  Macro       : SEG_SCAN_DP_EN adds DP_IN
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_mux_if;
    logic [31:0] VALUE;
    logic [7:0]  DIG_EN;
    logic        LOAD;
    logic        PENDING;
`ifdef SEG_SCAN_DP_EN
    logic [7:0]  DP_IN;
`endif

`ifdef SEG_SCAN_DP_EN
    modport master (output VALUE, output DIG_EN, output LOAD, output DP_IN, input PENDING);
    modport slave  (input VALUE, input DIG_EN, input LOAD, input DP_IN, output PENDING);
`else
    modport master (output VALUE, output DIG_EN, output LOAD, input PENDING);
    modport slave  (input VALUE, input DIG_EN, input LOAD, output PENDING);
`endif
endinterface
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex nibble to seven-segment glyph decoder.
//                i_nib - 4-bit hex digit
//                o_seg - active-high segments {a,b,c,d,e,f,g}
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = seg_glyph(i_nib);
endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Time-multiplexed driver for an 8-digit common-anode
//                seven-segment display. A captured word is shadowed only at
//                frame boundaries so digits never tear mid-frame.
//  Ports       : CLK100MHZ - system clock, rising edge
//                RST       - synchronous active-high reset
//                bus       - load bus (VALUE, DIG_EN, LOAD, PENDING[, DP_IN])
//                CA..CG    - segment cathodes, active low
//                AN[7:0]   - digit anodes, active low
//                DP        - decimal point cathode, active low (macro only)
//  Macro       : SEG_SCAN_DP_EN enables the decimal-point path
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int NUM_DIGITS  = 8
) (
    input  logic            CLK100MHZ,
    input  logic            RST,
    seg_scan_mux_if.slave   bus,
    output logic            CA,
    output logic            CB,
    output logic            CC,
    output logic            CD,
    output logic            CE,
    output logic            CF,
    output logic            CG,
`ifdef SEG_SCAN_DP_EN
    output logic            DP,
`endif
    output logic [7:0]      AN
);

    localparam int                 c_PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PW-1:0]    c_PRESC_MAX = c_PW'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   c_IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [c_PW-1:0]  r_presc_q,   w_presc_d;
    logic [IDX_W-1:0] r_idx_q,     w_idx_d;

    // Capture path: pending holds the latest LOAD, shadow feeds the display
    seg_word_t        r_pend_q,    w_pend_d;
    seg_word_t        r_shadow_q,  w_shadow_d;
    logic             r_pending_q, w_pending_d;

    // Registered outputs
    logic [7:0]       r_an_q,      w_an_d;
    logic [6:0]       r_seg_q,     w_seg_d;   // active-low {a..g}

    logic             w_tick;
    logic             w_boundary;
    logic             w_lit;
    logic [3:0]       w_nib;
    logic [6:0]       w_glyph;
    seg_word_t        w_load_word;

`ifdef SEG_SCAN_DP_EN
    logic [7:0]       r_pend_dp_q,   w_pend_dp_d;
    logic [7:0]       r_shadow_dp_q, w_shadow_dp_d;
    logic             r_dp_q,        w_dp_d;
`endif

    // Single decoder; its input follows the current scan index
    assign w_nib = r_shadow_q.value[{r_idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // ------------------------------------------------------------------
    // Prescaler, index and capture next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_load_word.value = bus.VALUE;
        w_load_word.en    = bus.DIG_EN;

        w_tick     = (r_presc_q == c_PRESC_MAX);
        w_boundary = w_tick && (r_idx_q == c_IDX_MAX);

        w_presc_d  = w_tick ? '0 : r_presc_q + 1'b1;
        w_idx_d    = r_idx_q;
        if (w_tick) begin
            w_idx_d = (r_idx_q == c_IDX_MAX) ? '0 : r_idx_q + 1'b1;
        end

        w_pend_d    = r_pend_q;
        w_shadow_d  = r_shadow_q;
        w_pending_d = r_pending_q;
`ifdef SEG_SCAN_DP_EN
        w_pend_dp_d   = r_pend_dp_q;
        w_shadow_dp_d = r_shadow_dp_q;
`endif

        if (w_boundary) begin
            // A LOAD landing exactly on the boundary bypasses the pending
            // stage and goes live for the next frame.
            if (bus.LOAD) begin
                w_pend_d   = w_load_word;
                w_shadow_d = w_load_word;
`ifdef SEG_SCAN_DP_EN
                w_pend_dp_d   = bus.DP_IN;
                w_shadow_dp_d = bus.DP_IN;
`endif
            end else if (r_pending_q) begin
                w_shadow_d = r_pend_q;
`ifdef SEG_SCAN_DP_EN
                w_shadow_dp_d = r_pend_dp_q;
`endif
            end
            w_pending_d = 1'b0;
        end else if (bus.LOAD) begin
            w_pend_d    = w_load_word;
            w_pending_d = 1'b1;
`ifdef SEG_SCAN_DP_EN
            w_pend_dp_d = bus.DP_IN;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output next-state: blank during the guard window or for disabled
    // digits, so at most one anode is ever driven low.
    // ------------------------------------------------------------------
    always_comb begin
        w_lit   = (int'(r_presc_q) >= GUARD) && r_shadow_q.en[r_idx_q];
        w_an_d  = 8'hFF;
        w_seg_d = ~SEG_OFF;
        if (w_lit) begin
            w_an_d  = ~(8'b1 << r_idx_q);
            w_seg_d = ~w_glyph;
        end
`ifdef SEG_SCAN_DP_EN
        w_dp_d = w_lit ? ~r_shadow_dp_q[r_idx_q] : 1'b1;
`endif
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_presc_q   <= '0;
            r_idx_q     <= '0;
            r_pend_q    <= '0;
            r_shadow_q  <= '0;
            r_pending_q <= 1'b0;
            r_an_q      <= 8'hFF;
            r_seg_q     <= 7'h7F;
`ifdef SEG_SCAN_DP_EN
            r_pend_dp_q   <= '0;
            r_shadow_dp_q <= '0;
            r_dp_q        <= 1'b1;
`endif
        end else begin
            r_presc_q   <= w_presc_d;
            r_idx_q     <= w_idx_d;
            r_pend_q    <= w_pend_d;
            r_shadow_q  <= w_shadow_d;
            r_pending_q <= w_pending_d;
            r_an_q      <= w_an_d;
            r_seg_q     <= w_seg_d;
`ifdef SEG_SCAN_DP_EN
            r_pend_dp_q   <= w_pend_dp_d;
            r_shadow_dp_q <= w_shadow_dp_d;
            r_dp_q        <= w_dp_d;
`endif
        end
    end

    assign bus.PENDING = r_pending_q;
    assign AN          = r_an_q;
    assign CA          = r_seg_q[6];
    assign CB          = r_seg_q[5];
    assign CC          = r_seg_q[4];
    assign CD          = r_seg_q[3];
    assign CE          = r_seg_q[2];
    assign CF          = r_seg_q[1];
    assign CG          = r_seg_q[0];
`ifdef SEG_SCAN_DP_EN
    assign DP          = r_dp_q;
`endif

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Sits downstream of the arithmetic/datapath stages and accepts a 32-bit hex word (8 nibbles) plus a per-digit enable mask.
- Scans one digit at a time with a refresh prescaler and drives active-low cathodes CA..CG and anodes AN[7:0].
- The displayed word updates only at frame boundaries, so a digit never changes value mid-frame (no tearing).

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; at 100 MHz this gives 1 kHz per digit and 125 Hz per frame. Minimum 2.
- GUARD, 16: cycles at the start of each slot during which all anodes are off (anti-ghosting). Must be < REFRESH_DIV.
- NUM_DIGITS, 8: digits scanned, from 1 to 8. AN[7:NUM_DIGITS] are held high.

Ports:
- CLK100MHZ  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- VALUE  input  32  hex word; nibble i is shown on digit i.
- DIG_EN  input  8  per-digit enable; 0 blanks that digit.
- LOAD  input  1  single-cycle strobe that captures VALUE and DIG_EN.
- PENDING  output  1  high while a captured value is waiting for the frame boundary.
- CA, CB, CC, CD, CE, CF, CG  output  1 each  segment cathodes, active low.
- AN  output  8  digit anodes, active low.

Behaviour:
- Reset, applied on any clock edge with RST=1, including mid-scan:
  - prescaler=0, digit index=0, PENDING=0
  - pending and shadow registers = 0 (VALUE and DIG_EN copies)
  - AN=8'hFF, CA..CG=1
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - A tick occurs in the cycle where prescaler==REFRESH_DIV-1.
  - On a tick the index advances, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary = a tick while index==NUM_DIGITS-1.
- LOAD handling:
  - LOAD=1 writes the pending registers and sets PENDING=1.
  - A later LOAD before the boundary overwrites the pending registers; the last LOAD wins.
- At a frame boundary with PENDING=1:
  - shadow <= pending and PENDING <= 0.
  - If LOAD=1 in the boundary cycle itself, the shadow takes the VALUE/DIG_EN presented in that cycle and PENDING stays 0.
- Output register, updated every cycle:
  - prescaler < GUARD, or the shadow enable bit for the current index is 0 → AN=8'hFF and CA..CG=1.
  - Otherwise AN = ~(1<<index), and CA..CG = ~decode(shadow nibble[index]).
  - Outputs lag the index and prescaler by exactly 1 cycle.
- Decode: standard hex glyphs 0-F (b,d lowercase; A,C,E,F uppercase). Segments a..g map to CA..CG.
- Glitch-free: every output comes directly from a flop. At most one AN bit is low in any cycle.

Optional Feature:
- Macro SEG_SCAN_DP_EN.
- When defined:
  - Adds input DP_IN[7:0], captured alongside VALUE on LOAD and shadowed identically.
  - Adds output DP, active low. DP = ~shadow_dp[index] when the digit is lit, else 1.
  - DP resets to 1.
- When undefined: neither port exists and no DP logic is generated.

Decomposition:
- Package seg_pkg:
  - Localparam SEG_OFF = 7'b0000000 (active-high internal).
  - Function for the 16-entry glyph table.
  - Index width constant $clog2(8)=3.
- Sub-module hex_to_seg: combinational, 4-bit in, 7-bit active-high out. Instantiated once; its input is muxed by index.

Test Plan (REFRESH_DIV=4, GUARD=1, NUM_DIGITS=8 unless stated):
- Reset, then LOAD VALUE=32'h76543210, DIG_EN=8'hFF:
  - PENDING is 1 until the first frame boundary (cycle 31), then 0.
  - During the following frame, AN steps FE, FD, FB … 7F.
  - Each slot is preceded by 1 cycle of FF.
  - Digit 0 shows glyph "0": CA..CG=0,0,0,0,0,0,1.
- LOAD 32'h000000AB mid-frame, then LOAD 32'h000000CD two cycles later:
  - The current frame still shows the old word.
  - The next frame shows "D" on digit 0 (CA..CG=1,0,0,0,0,1,0) and "C" on digit 1.
- LOAD asserted exactly in the boundary cycle:
  - The value takes effect immediately for the next frame.
  - PENDING never rises.
- DIG_EN=8'h01: only AN[0] ever goes low; all other slots read AN=FF with cathodes all 1.
- RST pulsed during digit 5's slot:
  - On the next cycle AN=FF, cathodes all 1, PENDING=0.
  - Scan restarts at digit 0 with a blank shadow (all digits dark until a LOAD reaches a boundary).
- SEG_SCAN_DP_EN defined, DP_IN=8'h04:
  - DP=0 only while AN=FB.
  - DP=1 during guard cycles and during every other slot.
